// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache.
//   LINE_BYTES / OFFSET_W : line geometry (16-byte lines, 4 offset bits)
//   ADDR_W / LINE_W       : CPU address width and memory line width
//   state_t               : controller FSM states
//   line_word()           : big-endian word select from a 128-bit line
package dcache_pkg;
  localparam int LINE_BYTES = 16;
  localparam int OFFSET_W   = 4;
  localparam int ADDR_W     = 32;
  localparam int LINE_W     = 128;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  // Word k lives in bits [127-32k -: 32]; byte 0 of the line is the MSB byte.
  function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line,
                                            input logic [1:0] k);
    logic [31:0] w;
    case (k)
      2'd0:    w = line[127:96];
      2'd1:    w = line[95:64];
      2'd2:    w = line[63:32];
      default: w = line[31:0];
    endcase
    return w;
  endfunction
endpackage

// File: rtl/dcache_line_store.sv
// Valid/tag/data storage for the direct-mapped cache.
//   clk, rst_n     : clock, asynchronous active-low clear of all arrays
//   i_rd_idx       : combinational read port index -> o_rd_valid/tag/line
//   i_fill_*       : full-line write (sets valid, writes tag and data)
//   i_wr_*         : single 32-bit word write into a resident line
//   i_inv_*        : clear the valid bit of one line
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int IW        = 4,
  parameter int TAG_W     = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IW-1:0]     i_rd_idx,
  output logic              o_rd_valid,
  output logic [TAG_W-1:0]  o_rd_tag,
  output logic [LINE_W-1:0] o_rd_line,
  input  logic              i_fill_en,
  input  logic [IW-1:0]     i_fill_idx,
  input  logic [TAG_W-1:0]  i_fill_tag,
  input  logic [LINE_W-1:0] i_fill_line,
  input  logic              i_wr_en,
  input  logic [IW-1:0]     i_wr_idx,
  input  logic [1:0]        i_wr_word,
  input  logic [31:0]       i_wr_data,
  input  logic              i_inv_en,
  input  logic [IW-1:0]     i_inv_idx
);
  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [LINE_W-1:0]    r_data [NUM_LINES];

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_line  = r_data[i_rd_idx];

  // Data is cleared too so that the read port shows zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (i_fill_en) begin
        r_valid[i_fill_idx] <= 1'b1;
        r_tag[i_fill_idx]   <= i_fill_tag;
        r_data[i_fill_idx]  <= i_fill_line;
      end
      if (i_wr_en) begin
        r_data[i_wr_idx][LINE_W-1-32*i_wr_word -: 32] <= i_wr_data;
      end
      if (i_inv_en) begin
        r_valid[i_inv_idx] <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
//   CPU side : cpu_req, cpu_we, cpu_addr, cpu_wdata -> cpu_rdata, cpu_stall
//   Memory   : mem_we, mem_addr, mem_wdata -> mem_rdata (128-bit line)
//   Stats    : stat_hits, stat_misses (active only with DCACHE_STATS_EN
//              defined; otherwise tied to zero)
// Load misses stall for MEM_LATENCY+1 cycles; stores always go to memory.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES   = 16,
  parameter int MEM_LATENCY = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
);
  localparam int IW    = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - OFFSET_W - IW;
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [31:0]        r_mem_wdata;

  logic               w_req;
  logic [IW-1:0]      w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_valid;
  logic [TAG_W-1:0]   w_line_tag;
  logic [LINE_W-1:0]  w_line;
  logic               w_hit;
  logic               w_load_hit;
  logic               w_load_miss;
  logic               w_store;
  logic               w_fill_done;
  logic               w_stall;
  logic               w_mem_we;
  logic [ADDR_W-1:0]  w_mem_addr;
  logic [31:0]        w_mem_wdata;

  // Gating with rst_n keeps every output at its reset value while reset is
  // held, even if the CPU is presenting a request.
  assign w_req      = cpu_req & rst_n;
  assign w_idx      = cpu_addr[OFFSET_W+IW-1:OFFSET_W];
  assign w_tag      = cpu_addr[ADDR_W-1:OFFSET_W+IW];
  assign w_hit      = w_valid && (w_line_tag == w_tag);

  assign w_load_hit  = (r_state == IDLE) && w_req && !cpu_we && w_hit;
  assign w_load_miss = (r_state == IDLE) && w_req && !cpu_we && !w_hit;
  assign w_store     = (r_state == IDLE) && w_req && cpu_we;
  assign w_fill_done = (r_state == FILL) && (r_cnt == CNT_W'(MEM_LATENCY - 1));

  always_comb begin
    w_stall     = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    if (r_state == FILL) begin
      w_stall = 1'b1;
    end else if (w_store) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = cpu_addr;
      w_mem_wdata = cpu_wdata;
    end else if (w_load_miss) begin
      w_stall    = 1'b1;
      w_mem_addr = {cpu_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    end
  end

  assign cpu_stall = w_stall;
  assign mem_we    = w_mem_we;
  assign mem_addr  = w_mem_addr;
  assign mem_wdata = w_mem_wdata;
  assign cpu_rdata = line_word(w_line, cpu_addr[3:2]);

  // mem_addr/mem_wdata hold their last driven value, so an idle cycle does
  // not present a new address that would restart the memory's latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      case (r_state)
        IDLE: begin
          if (w_load_miss) begin
            r_state <= FILL;
            r_cnt   <= '0;
          end
        end
        FILL: begin
          if (w_fill_done) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The fill index/tag come from the held line address, not from cpu_addr.
  dcache_line_store #(
    .NUM_LINES (NUM_LINES),
    .IW        (IW),
    .TAG_W     (TAG_W)
  ) u_store (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rd_idx    (w_idx),
    .o_rd_valid  (w_valid),
    .o_rd_tag    (w_line_tag),
    .o_rd_line   (w_line),
    .i_fill_en   (w_fill_done),
    .i_fill_idx  (r_mem_addr[OFFSET_W+IW-1:OFFSET_W]),
    .i_fill_tag  (r_mem_addr[ADDR_W-1:OFFSET_W+IW]),
    .i_fill_line (mem_rdata),
    .i_wr_en     (w_store && w_hit && (cpu_addr[1:0] == 2'b00)),
    .i_wr_idx    (w_idx),
    .i_wr_word   (cpu_addr[3:2]),
    .i_wr_data   (cpu_wdata),
    .i_inv_en    (w_store && w_hit && (cpu_addr[1:0] != 2'b00)),
    .i_inv_idx   (w_idx)
  );

`ifdef DCACHE_STATS_EN
  logic [31:0] r_hits;
  logic [31:0] r_misses;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hits   <= '0;
      r_misses <= '0;
    end else begin
      if (w_load_hit && (r_hits != 32'hFFFF_FFFF)) begin
        r_hits <= r_hits + 32'd1;
      end
      if (w_load_miss && (r_misses != 32'hFFFF_FFFF)) begin
        r_misses <= r_misses + 32'd1;
      end
    end
  end

  assign stat_hits   = r_hits;
  assign stat_misses = r_misses;
`else
  logic w_unused_stats;
  assign w_unused_stats = w_load_hit;
  assign stat_hits      = '0;
  assign stat_misses    = '0;
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;
  logic         clk;
  logic         rst_n;
  logic         cpu_req;
  logic         cpu_we;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         cpu_stall;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [127:0] mem_rdata;
  logic [31:0]  stat_hits;
  logic [31:0]  stat_misses;

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  dcache_ctrl #(.NUM_LINES(16), .MEM_LATENCY(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed memory model; default word at byte address a is C0DE_<a>.
  logic [31:0] mem [0:1023];
  logic [9:0]  mbase;
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 | (i * 4);
  end
  always @(negedge clk) begin
    if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
  end
  assign mbase     = {mem_addr[11:4], 2'b00};
  assign mem_rdata = {mem[mbase], mem[mbase + 10'd1], mem[mbase + 10'd2], mem[mbase + 10'd3]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_stats(input string name);
`ifdef DCACHE_STATS_EN
    chk({name, "_hits"}, stat_hits, exp_hits);
    chk({name, "_misses"}, stat_misses, exp_misses);
`else
    chk({name, "_hits"}, stat_hits, 32'd0);
    chk({name, "_misses"}, stat_misses, 32'd0);
`endif
  endtask

  // Waits (bounded) for cpu_stall to drop, sampling just after negedges.
  task automatic count_stalls(output int stalls);
    stalls = 0;
    while (cpu_stall && stalls < 30) begin
      stalls++;
      @(negedge clk); #1;
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_stall;
    logic [31:0] exp_rdata;
    logic [31:0] exp_maddr;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int stalls;
    logic        first_we;
    logic [31:0] first_maddr;
    logic [31:0] first_mwdata;

    vecs[0]  = '{1'b0, 32'h40,  32'h0,        7, 32'hC0DE0040, 32'h40};  // cold miss
    vecs[1]  = '{1'b0, 32'h44,  32'h0,        0, 32'hC0DE0044, 32'h40};  // hit, addr held
    vecs[2]  = '{1'b1, 32'h48,  32'hDEADBEEF, 0, 32'h0,        32'h48};  // store hit
    vecs[3]  = '{1'b0, 32'h48,  32'h0,        0, 32'hDEADBEEF, 32'h48};
    vecs[4]  = '{1'b1, 32'h200, 32'h12345678, 0, 32'h0,        32'h200}; // store miss
    vecs[5]  = '{1'b0, 32'h200, 32'h0,        7, 32'h12345678, 32'h200};
    vecs[6]  = '{1'b0, 32'h140, 32'h0,        7, 32'hC0DE0140, 32'h140}; // conflict
    vecs[7]  = '{1'b0, 32'h40,  32'h0,        7, 32'hC0DE0040, 32'h40};
    vecs[8]  = '{1'b0, 32'h4C,  32'h0,        0, 32'hC0DE004C, 32'h40};
    vecs[9]  = '{1'b1, 32'h42,  32'h0BADF00D, 0, 32'h0,        32'h42};  // misaligned
    vecs[10] = '{1'b0, 32'h40,  32'h0,        7, 32'h0BADF00D, 32'h40};
    vecs[11] = '{1'b0, 32'h48,  32'h0,        0, 32'hDEADBEEF, 32'h40};

    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    #12;
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk_stats("rst");
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = vecs[i].we;
      cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].wdata;
      @(negedge clk); #1;
      first_we = mem_we; first_maddr = mem_addr; first_mwdata = mem_wdata;
      count_stalls(stalls);
      chk($sformatf("v%0d_stall", i), stalls, vecs[i].exp_stall);
      chk($sformatf("v%0d_mem_we", i), {31'd0, first_we}, {31'd0, vecs[i].we});
      chk($sformatf("v%0d_mem_addr", i), first_maddr, vecs[i].exp_maddr);
      if (vecs[i].we) begin
        chk($sformatf("v%0d_mem_wdata", i), first_mwdata, vecs[i].wdata);
      end else begin
        chk($sformatf("v%0d_rdata", i), cpu_rdata, vecs[i].exp_rdata);
        chk($sformatf("v%0d_mem_we_end", i), {31'd0, mem_we}, 32'd0);
        if (vecs[i].exp_stall > 0) exp_misses++;
        exp_hits++;
      end
    end
    @(posedge clk); #1; cpu_req = 1'b0;
    @(posedge clk); #1;
    chk("idle_mem_we", {31'd0, mem_we}, 32'd0);
    chk("idle_mem_addr_hold", mem_addr, 32'h40);
    chk_stats("after_table");

    // Reset during the third FILL cycle, request held throughout.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
    @(negedge clk); #1;
    chk("rf_detect_stall", {31'd0, cpu_stall}, 32'd1);
    repeat (3) @(posedge clk);
    #3;
    chk("rf_fill_stall", {31'd0, cpu_stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    exp_hits = 0; exp_misses = 0;
    chk("rf_stall_dropped", {31'd0, cpu_stall}, 32'd0);
    chk("rf_mem_we", {31'd0, mem_we}, 32'd0);
    chk_stats("rf_reset");
    @(negedge clk); rst_n = 1'b1; #1;
    count_stalls(stalls);
    chk("rf_refill_stall", stalls, 32'd7);
    chk("rf_refill_rdata", cpu_rdata, 32'hC0DE0080);
    exp_misses++; exp_hits++;
    // Valid bits were cleared, so the previously resident line misses.
    @(posedge clk); #1; cpu_addr = 32'h40;
    @(negedge clk); #1;
    count_stalls(stalls);
    chk("rf_cleared_stall", stalls, 32'd7);
    chk("rf_cleared_rdata", cpu_rdata, 32'h0BADF00D);
    exp_misses++; exp_hits++;
    @(posedge clk); #1; cpu_req = 1'b0;
    @(posedge clk); #1;
    chk_stats("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
